// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// Multicycle control FSM for the 16-register / ALU datapath. It accepts one
// instruction per handshake, decodes it, drives the operand selects, the
// immediate and the ALU opcode for EXEC_CYCLES cycles, and then issues a
// single write-back cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   instr_valid  instr_in is valid
//   instr_in     16-bit instruction word
//   instr_ready  sequencer can accept an instruction
//   ra_sel       A-operand mux select (Rdest)
//   rb_sel       B-operand mux select (Rsrc)
//   imm_sel      1 = ALU B input takes imm_out
//   imm_out      extended immediate
//   alu_op       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
//   reg_we       one-hot register write enable
//   flag_we      flag register write enable
//   done         one-cycle completion pulse
//   illegal      one-cycle pulse for an undecodable instruction
//
// state  | meaning
// IDLE   | waiting for a handshake (instr_ready high once armed)
// DECODE | latched instruction is decoded, exec counter loaded
// EXEC   | operands/opcode driven while the ALU settles
// WB     | write enables and done pulse for one cycle

module datapath_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter bit PROTECT_R0  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr_in,
  output logic        instr_ready,
  output logic [3:0]  ra_sel,
  output logic [3:0]  rb_sel,
  output logic        imm_sel,
  output logic [15:0] imm_out,
  output logic [2:0]  alu_op,
  output logic [15:0] reg_we,
  output logic        flag_we,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;

  localparam logic [1:0] CNT_LOAD = 2'(EXEC_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] instr_q;
  logic [1:0]  cnt, cnt_nxt;
  // Keeps instr_ready low until the first clock edge after reset release.
  logic        armed;

  logic [3:0]  op, ext, code, rdest;
  logic        is_imm, legal, sext, writes_reg, writes_flag, active;
  logic [2:0]  dec_alu;
  logic [15:0] imm_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      instr_q <= '0;
      cnt     <= '0;
      armed   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= 1'b1;
      if (state == IDLE && armed && instr_valid)
        instr_q <= instr_in;
    end
  end

  // Register form (op=0) is decoded by ext; immediate forms reuse the same
  // codes in the op field, so both collapse onto one case statement.
  always_comb begin
    op          = instr_q[15:12];
    ext         = instr_q[7:4];
    rdest       = instr_q[11:8];
    is_imm      = (op != 4'd0);
    code        = is_imm ? op : ext;
    legal       = 1'b1;
    sext        = 1'b0;
    writes_reg  = 1'b1;
    writes_flag = 1'b0;
    dec_alu     = ALU_ADD;
    case (code)
      4'b0101: begin dec_alu = ALU_ADD; writes_flag = 1'b1; sext = 1'b1; end
      4'b1001: begin dec_alu = ALU_SUB; writes_flag = 1'b1; sext = 1'b1; end
      4'b0001: dec_alu = ALU_AND;
      4'b0010: dec_alu = ALU_OR;
      4'b0011: dec_alu = ALU_XOR;
      4'b1011: begin
        dec_alu     = ALU_SUB;
        writes_flag = 1'b1;
        writes_reg  = 1'b0;
        sext        = 1'b1;
      end
      4'b1101: dec_alu = ALU_PASS;
      default: begin legal = 1'b0; writes_reg = 1'b0; end
    endcase
    imm_ext = sext ? {{8{instr_q[7]}}, instr_q[7:0]} : {8'h00, instr_q[7:0]};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   if (armed && instr_valid) state_nxt = DECODE;
      DECODE: begin
        if (legal) begin
          state_nxt = EXEC;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = WB;
        end
      end
      EXEC: begin
        if (cnt == 2'd0) state_nxt = WB;
        else             cnt_nxt   = cnt - 2'd1;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs derive from the state register and the latched instruction,
  // which is frozen outside IDLE, so they are stable through EXEC and WB.
  always_comb begin
    instr_ready = (state == IDLE) && armed;
    ra_sel      = '0;
    rb_sel      = '0;
    imm_sel     = 1'b0;
    imm_out     = '0;
    alu_op      = '0;
    reg_we      = '0;
    flag_we     = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    active      = ((state == EXEC) || (state == WB)) && legal;
    if (active) begin
      ra_sel  = rdest;
      rb_sel  = instr_q[3:0];
      imm_sel = is_imm;
      imm_out = is_imm ? imm_ext : 16'h0000;
      alu_op  = dec_alu;
    end
    if (state == WB) begin
      done    = 1'b1;
      illegal = ~legal;
      if (legal) begin
        flag_we = writes_flag;
        if (writes_reg && !(PROTECT_R0 && rdest == 4'd0))
          reg_we = 16'h0001 << rdest;
      end
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: one instance with EXEC_CYCLES=1,
// PROTECT_R0=0 and one with EXEC_CYCLES=3, PROTECT_R0=1. Expected write-back
// results are queued at the handshake and checked when done pulses.

module tb_datapath_sequencer;

  typedef struct {
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        imm_sel;
    logic [15:0] imm;
    logic [2:0]  alu;
    logic [15:0] we;
    logic        fwe;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  int          which = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  logic        a_ready, a_imm_sel, a_fwe, a_done, a_ill;
  logic [3:0]  a_ra, a_rb;
  logic [15:0] a_imm, a_we;
  logic [2:0]  a_alu;
  logic        b_ready, b_imm_sel, b_fwe, b_done, b_ill;
  logic [3:0]  b_ra, b_rb;
  logic [15:0] b_imm, b_we;
  logic [2:0]  b_alu;

  logic        o_ready, o_imm_sel, o_fwe, o_done, o_ill;
  logic [3:0]  o_ra, o_rb;
  logic [15:0] o_imm, o_we;
  logic [2:0]  o_alu;

  logic va, vb;
  assign va = valid && (which == 0);
  assign vb = valid && (which == 1);

  datapath_sequencer #(.EXEC_CYCLES(1), .PROTECT_R0(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .instr_valid(va), .instr_in(instr),
    .instr_ready(a_ready), .ra_sel(a_ra), .rb_sel(a_rb), .imm_sel(a_imm_sel),
    .imm_out(a_imm), .alu_op(a_alu), .reg_we(a_we), .flag_we(a_fwe),
    .done(a_done), .illegal(a_ill));

  datapath_sequencer #(.EXEC_CYCLES(3), .PROTECT_R0(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .instr_valid(vb), .instr_in(instr),
    .instr_ready(b_ready), .ra_sel(b_ra), .rb_sel(b_rb), .imm_sel(b_imm_sel),
    .imm_out(b_imm), .alu_op(b_alu), .reg_we(b_we), .flag_we(b_fwe),
    .done(b_done), .illegal(b_ill));

  always_comb begin
    if (which == 0) begin
      o_ready = a_ready; o_ra = a_ra; o_rb = a_rb; o_imm_sel = a_imm_sel;
      o_imm = a_imm; o_alu = a_alu; o_we = a_we; o_fwe = a_fwe;
      o_done = a_done; o_ill = a_ill;
    end else begin
      o_ready = b_ready; o_ra = b_ra; o_rb = b_rb; o_imm_sel = b_imm_sel;
      o_imm = b_imm; o_alu = b_alu; o_we = b_we; o_fwe = b_fwe;
      o_done = b_done; o_ill = b_ill;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {o_ready, o_ra, o_rb, o_imm_sel, o_alu, o_fwe, o_done, o_ill}, 64'h0);
    chk({tag, "_imm_we"}, {o_imm, o_we}, 64'h0);
  endtask

  function automatic exp_t mk(input logic [3:0] ra, input logic [3:0] rb,
                              input logic is, input logic [15:0] imm,
                              input logic [2:0] alu, input logic [15:0] we,
                              input logic fwe, input logic ill, input int lat);
    exp_t e;
    e.ra = ra; e.rb = rb; e.imm_sel = is; e.imm = imm; e.alu = alu;
    e.we = we; e.fwe = fwe; e.ill = ill; e.lat = lat;
    return e;
  endfunction

  task automatic run_instr(input int w, input logic [15:0] ins, input exp_t e, input int ec);
    bit   seen;
    exp_t got;
    which = w;
    @(negedge clk);
    chk("ready_before", o_ready, 1);
    instr = ins;
    valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1;
    valid = 1'b0;
    instr = 16'h0000;
    seen  = 0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1;
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          got = sb.pop_front();
          chk("latency", cyc, got.lat);
          chk("wb_reg_we", o_we, got.we);
          chk("wb_flag_we", o_fwe, got.fwe);
          chk("wb_illegal", o_ill, got.ill);
          chk("wb_ready", o_ready, 0);
          if (!got.ill)
            chk("wb_ops", {o_ra, o_rb, o_imm_sel, o_imm, o_alu},
                {got.ra, got.rb, got.imm_sel, got.imm, got.alu});
        end
      end else begin
        chk("no_we_early", {o_we, o_fwe, o_ill}, 0);
        chk("busy_ready", o_ready, 0);
        if (cyc == 1)
          chk("decode_ops_zero", {o_ra, o_rb, o_imm_sel, o_imm, o_alu}, 0);
        else if (!e.ill && cyc <= ec + 1)
          chk("exec_ops", {o_ra, o_rb, o_imm_sel, o_imm, o_alu},
              {e.ra, e.rb, e.imm_sel, e.imm, e.alu});
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("ready_after", o_ready, 1);
    chk("idle_ops_zero", {o_ra, o_rb, o_imm_sel, o_imm, o_alu, o_we, o_fwe, o_done}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset behaviour on both instances
    #2;
    which = 0; chk_all_zero("reset_a");
    which = 1; chk_all_zero("reset_b");
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    which = 0; chk("ready_pre_edge_a", o_ready, 0);
    which = 1; chk("ready_pre_edge_b", o_ready, 0);
    @(negedge clk);
    which = 0; chk("ready_post_edge_a", o_ready, 1);
    which = 1; chk("ready_post_edge_b", o_ready, 1);

    // EXEC_CYCLES=1, PROTECT_R0=0
    run_instr(0, 16'h0355, mk(4'd3, 4'd5, 1'b0, 16'h0000, 3'd0, 16'h0008, 1'b1, 1'b0, 3), 1); // ADD R3,R5
    run_instr(0, 16'h52FF, mk(4'd2, 4'hF, 1'b1, 16'hFFFF, 3'd0, 16'h0004, 1'b1, 1'b0, 3), 1); // ADDI R2,#-1
    run_instr(0, 16'h2780, mk(4'd7, 4'd0, 1'b1, 16'h0080, 3'd3, 16'h0080, 1'b0, 1'b0, 3), 1); // ORI R7,#0x80
    run_instr(0, 16'h01B4, mk(4'd1, 4'd4, 1'b0, 16'h0000, 3'd1, 16'h0000, 1'b1, 1'b0, 3), 1); // CMP R1,R4
    run_instr(0, 16'hF000, mk(4'd0, 4'd0, 1'b0, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1, 2), 1); // illegal op
    run_instr(0, 16'h0170, mk(4'd0, 4'd0, 1'b0, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1, 2), 1); // illegal ext
    run_instr(0, 16'h0094, mk(4'd0, 4'd4, 1'b0, 16'h0000, 3'd1, 16'h0001, 1'b1, 1'b0, 3), 1); // SUB R0,R4
    run_instr(0, 16'h1FF0, mk(4'hF, 4'd0, 1'b1, 16'h00F0, 3'd2, 16'h8000, 1'b0, 1'b0, 3), 1); // ANDI R15,#0xF0
    run_instr(0, 16'h3480, mk(4'd4, 4'd0, 1'b1, 16'h0080, 3'd4, 16'h0010, 1'b0, 1'b0, 3), 1); // XORI R4,#0x80
    run_instr(0, 16'h9680, mk(4'd6, 4'd0, 1'b1, 16'hFF80, 3'd1, 16'h0040, 1'b1, 1'b0, 3), 1); // SUBI R6,#-128
    run_instr(0, 16'hB907, mk(4'd9, 4'd7, 1'b1, 16'h0007, 3'd1, 16'h0000, 1'b1, 1'b0, 3), 1); // CMPI R9,#7

    // EXEC_CYCLES=3, PROTECT_R0=1
    run_instr(1, 16'hD005, mk(4'd0, 4'd5, 1'b1, 16'h0005, 3'd5, 16'h0000, 1'b0, 1'b0, 5), 3); // MOVI R0,#5
    run_instr(1, 16'h02D3, mk(4'd2, 4'd3, 1'b0, 16'h0000, 3'd5, 16'h0004, 1'b0, 1'b0, 5), 3); // MOV R2,R3

    // reset asserted in the middle of EXEC
    which = 1;
    @(negedge clk);
    instr = 16'h0355;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    instr = 16'h0000;
    @(negedge clk);                       // cycle 1, DECODE
    @(negedge clk);                       // cycle 2, EXEC
    chk("midrst_exec_ra", o_ra, 3);
    @(negedge clk);                       // cycle 3, EXEC
    rst_b = 1'b1;
    #1;
    chk_all_zero("midrst_immediate");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_all_zero("midrst_hold");
    end
    rst_b = 1'b0;
    #1;
    chk("midrst_ready_pre_edge", o_ready, 0);
    @(negedge clk);
    chk("midrst_ready_post_edge", o_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_wb", {o_done, o_we, o_fwe, o_ill}, 0);
    end
    chk("midrst_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multicycle control FSM for the 16-register / ALU datapath.
- Accepts one 16-bit instruction per handshake and decodes it.
- Drives the A/B operand select lines of the two 16:1 register-read muxes, the immediate path, the ALU opcode, and the one-hot register-file and flag write enables.
- Sits between instruction fetch and the register file/ALU; exactly one instruction is in flight at a time.

Parameters:
- EXEC_CYCLES, 1: number of cycles spent in EXEC. Legal range 1..4; gives multicycle settling time for a slow ALU.
- PROTECT_R0, 0: when 1, register-write enables targeting r0 are suppressed (flags are still written).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr_valid  input  1  instr_in is valid
- instr_in  input  16  instruction word
- instr_ready  output  1  sequencer can accept an instruction
- ra_sel  output  4  A-operand mux select (Rdest field)
- rb_sel  output  4  B-operand mux select (Rsrc field)
- imm_sel  output  1  1 = ALU B input takes imm_out instead of the rb mux output
- imm_out  output  16  extended immediate
- alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
- reg_we  output  16  one-hot register write enable
- flag_we  output  1  flag register write enable
- done  output  1  one-cycle completion pulse
- illegal  output  1  one-cycle pulse: undecodable instruction

Behaviour:
- States: IDLE, DECODE, EXEC, WB.
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - state goes to IDLE and the latched instruction is cleared.
  - All outputs are 0, including instr_ready.
  - An in-flight instruction is abandoned; no reg_we or flag_we is produced for it.
- IDLE:
  - instr_ready=1 from the first clock edge after reset is released.
  - Handshake completes on a rising edge with instr_valid & instr_ready. instr_in is latched, then go to DECODE.
  - instr_ready=0 in every other state. instr_valid is ignored outside IDLE.
- Instruction format: [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc or imm[3:0]; imm8=[7:0].
- Register form, op=0000, decoded by ext:
  - 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR, 1011 CMP, 1101 MOV.
  - Any other ext value is illegal.
- Immediate form, decoded by op (same codes as ext above):
  - 0101 ADDI, 1001 SUBI, 0001 ANDI, 0010 ORI, 0011 XORI, 1011 CMPI, 1101 MOVI.
  - Any other op value is illegal.
- Immediate extension:
  - ADDI, SUBI, CMPI: sign-extend imm8 to 16 bits.
  - ANDI, ORI, XORI, MOVI: zero-extend imm8.
- alu_op mapping: ADD/ADDI=0; SUB/SUBI/CMP/CMPI=1; AND/ANDI=2; OR/ORI=3; XOR/XORI=4; MOV/MOVI=5 (PASS_B).
- DECODE (1 cycle):
  - Legal instruction: go to EXEC and load the exec counter with EXEC_CYCLES-1.
  - Illegal instruction: go directly to WB with the write enables forced to 0.
- EXEC:
  - ra_sel=Rdest, rb_sel=Rsrc, imm_sel, imm_out and alu_op are driven, registered, and stable.
  - The counter decrements each cycle; go to WB when it reaches 0.
- WB (exactly 1 cycle), then go to IDLE:
  - Selects, imm and alu_op are held unchanged.
  - reg_we = 1<<Rdest for every legal instruction except CMP/CMPI; forced to 0 when PROTECT_R0=1 and Rdest=0.
  - flag_we=1 for ADD/ADDI/SUB/SUBI/CMP/CMPI; 0 for logical ops and moves.
  - done=1. illegal=1 only on the illegal path.
- Operand outputs outside EXEC/WB: ra_sel, rb_sel, imm_sel, imm_out and alu_op are 0.
- reg_we is always zero or one-hot; never multi-hot.
- Latency for a legal instruction: handshake edge at cycle 0; WB in cycle 2+EXEC_CYCLES; instr_ready is high again the following cycle.
- Illegal latency: WB in cycle 2.
- Throughput: 1 instruction per 3+EXEC_CYCLES cycles.

Test Plan:
- ADD R3,R5: handshake 16'h0355 with EXEC_CYCLES=1 -> in EXEC: ra_sel=3, rb_sel=5, imm_sel=0, alu_op=0. In WB (cycle 3): reg_we=16'h0008, flag_we=1, done=1. instr_ready=1 in cycle 4.
- ADDI R2,#-1: handshake 16'h52FF -> imm_sel=1, imm_out=16'hFFFF, alu_op=0, reg_we=16'h0004, flag_we=1.
- ORI R7,#0x80 (16'h2780): imm_out=16'h0080, alu_op=3, reg_we=16'h0080, flag_we=0.
- CMP R1,R4 (16'h01B4): alu_op=1, reg_we=0 throughout, flag_we=1 for one cycle, done=1.
- Illegal 16'hF000 -> illegal=1 and done=1 in cycle 2, reg_we and flag_we never asserted, instr_ready=1 in cycle 3.
- Reset/config cases:
  - reset asserted mid-EXEC with EXEC_CYCLES=3 -> all outputs 0 immediately, no WB pulse; instr_ready=1 one edge after release.
  - PROTECT_R0=1 with MOVI R0,#5 (16'hD005) -> done=1, reg_we=0.
